// File: rtl/config_reg_slave.sv
// config_reg_slave: addressed register-file slave with a one-deep read response
// register, read-before-write on collisions and out-of-range error flagging.
module config_reg_slave #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 16,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  r_en,
  input  logic                  w_en,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] write_data,
  output logic                  req_ready,
  output logic [DATA_WIDTH-1:0] read_data,
  output logic                  read_valid,
  input  logic                  read_ready,
  output logic                  read_err
);

  typedef enum logic {
    IDLE = 1'b0,
    RESP = 1'b1
  } state_t;

  localparam int unsigned DEPTH_U = DEPTH;

  state_t                  state_q, state_d;
  logic [DATA_WIDTH-1:0]   data_q, data_d;
  logic                    err_q, err_d;
  logic [DATA_WIDTH-1:0]   mem_q [DEPTH];
  logic [DATA_WIDTH-1:0]   rd_word;
  logic [31:0]             addr_ext;
  logic                    in_range;
  logic                    rd_fire;
  logic                    wr_fire;

  assign addr_ext  = 32'(addr);
  assign in_range  = (addr_ext < DEPTH_U);
  assign req_ready = (state_q == IDLE) || read_ready;
  assign rd_fire   = r_en && req_ready;
  assign wr_fire   = w_en && req_ready && in_range;

  // Read mux over the flop array; out-of-range addresses fall through to zero.
  always_comb begin
    rd_word = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (addr_ext == 32'(i)) rd_word = mem_q[i];
    end
  end

  // Words are flops rather than RAM because reset must clear every entry.
  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_mem
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          mem_q[gi] <= '0;
        end else if (wr_fire && (addr_ext == 32'(gi))) begin
          mem_q[gi] <= write_data;
        end
      end
    end
  endgenerate

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    err_d   = err_q;
    if (rd_fire) begin
      // rd_word is sampled before the same-cycle write lands: read-before-write.
      state_d = RESP;
      data_d  = in_range ? rd_word : '0;
      err_d   = !in_range;
    end else if ((state_q == RESP) && read_ready) begin
      state_d = IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      data_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      err_q   <= err_d;
    end
  end

  assign read_valid = (state_q == RESP);
  assign read_data  = data_q;
  assign read_err   = err_q;

endmodule

// File: tb/tb_config_reg_slave.sv
// Directed bench for config_reg_slave (DEPTH=12): a bench-side memory model feeds
// a scoreboard of expected read responses that are compared as the DUT returns them.
module tb_config_reg_slave;

  localparam int DW    = 8;
  localparam int DEPTH = 12;
  localparam int AW    = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          r_en = 1'b0;
  logic          w_en = 1'b0;
  logic          read_ready = 1'b0;
  logic [AW-1:0] addr = '0;
  logic [DW-1:0] write_data = '0;
  logic          req_ready;
  logic          read_valid;
  logic          read_err;
  logic [DW-1:0] read_data;

  always #5 clk = ~clk;

  config_reg_slave #(
    .DATA_WIDTH(DW),
    .DEPTH     (DEPTH),
    .ADDR_WIDTH(AW)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .r_en      (r_en),
    .w_en      (w_en),
    .addr      (addr),
    .write_data(write_data),
    .req_ready (req_ready),
    .read_data (read_data),
    .read_valid(read_valid),
    .read_ready(read_ready),
    .read_err  (read_err)
  );

  int            checks = 0;
  int            errors = 0;
  logic [DW:0]   exp_q[$];          // {err, data}
  logic [DW-1:0] model_mem [DEPTH];
  logic          pend = 1'b0;
  logic [DW-1:0] cur_data = '0;
  logic          cur_err = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock of stimulus: drive, check req_ready, update model, then check outputs.
  task automatic cycle(input logic r, input logic w, input logic [AW-1:0] a,
                       input logic [DW-1:0] wd, input logic rr);
    logic        acc;
    logic        new_resp;
    logic [DW:0] e;
    r_en = r; w_en = w; addr = a; write_data = wd; read_ready = rr;
    #1;
    chk("req_ready", 32'(req_ready), 32'(!pend || rr));
    acc      = (r || w) && (!pend || rr);
    new_resp = acc && r;
    if (new_resp) begin
      if (32'(a) < DEPTH) exp_q.push_back({1'b0, model_mem[a]});
      else                exp_q.push_back({1'b1, {DW{1'b0}}});
    end
    if (acc && w) begin
      if (32'(a) < DEPTH) model_mem[a] = wd;
      $display("write addr %0d data %0h accepted", a, wd);
    end
    if (new_resp) pend = 1'b1;
    else if (pend && rr) pend = 1'b0;
    @(posedge clk);
    #1;
    if (new_resp) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL scoreboard_empty observed 0 expected 1");
      end else begin
        e        = exp_q.pop_front();
        cur_err  = e[DW];
        cur_data = e[DW-1:0];
        $display("read addr %0d -> data %0h err %0b (expected %0h err %0b)",
                 a, read_data, read_err, cur_data, cur_err);
      end
    end
    chk("read_valid", 32'(read_valid), 32'(pend));
    chk("read_data", 32'(read_data), 32'(cur_data));
    if (pend) chk("read_err", 32'(read_err), 32'(cur_err));
  endtask

  task automatic do_reset(input int n);
    rst_n = 1'b0; r_en = 1'b0; w_en = 1'b0; read_ready = 1'b0;
    repeat (n) @(posedge clk);
    #1;
    rst_n = 1'b1;
    pend = 1'b0; cur_data = '0; cur_err = 1'b0;
    exp_q.delete();
    for (int i = 0; i < DEPTH; i++) model_mem[i] = '0;
    $display("reset for %0d cycles", n);
    chk("rst_read_valid", 32'(read_valid), 32'(0));
    chk("rst_read_data", 32'(read_data), 32'(0));
    chk("rst_read_err", 32'(read_err), 32'(0));
  endtask

  task automatic sweep();
    for (int i = 0; i < DEPTH; i++) cycle(1'b1, 1'b0, AW'(i), '0, 1'b1);
    cycle(1'b0, 1'b0, '0, '0, 1'b1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset and readback
    do_reset(2);
    sweep();

    // Write then read
    cycle(1'b0, 1'b1, 4'd3, 8'hA5, 1'b1);
    cycle(1'b1, 1'b0, 4'd3, 8'h00, 1'b1);
    cycle(1'b1, 1'b0, 4'd4, 8'h00, 1'b1);
    cycle(1'b0, 1'b0, 4'd0, 8'h00, 1'b1);

    // Collision: read-before-write
    cycle(1'b0, 1'b1, 4'd5, 8'h11, 1'b1);
    cycle(1'b1, 1'b1, 4'd5, 8'h22, 1'b1);
    cycle(1'b1, 1'b0, 4'd5, 8'h00, 1'b1);
    cycle(1'b0, 1'b0, 4'd0, 8'h00, 1'b1);

    // Backpressure with a held write
    cycle(1'b1, 1'b0, 4'd3, 8'h00, 1'b1);
    repeat (4) cycle(1'b0, 1'b1, 4'd6, 8'h66, 1'b0);
    cycle(1'b0, 1'b1, 4'd6, 8'h66, 1'b1);
    cycle(1'b1, 1'b0, 4'd6, 8'h00, 1'b1);
    cycle(1'b0, 1'b0, 4'd0, 8'h00, 1'b1);

    // Out of range
    cycle(1'b0, 1'b1, 4'd13, 8'hFF, 1'b1);
    cycle(1'b1, 1'b0, 4'd13, 8'h00, 1'b1);
    cycle(1'b1, 1'b0, 4'd15, 8'h00, 1'b1);
    cycle(1'b0, 1'b0, 4'd0, 8'h00, 1'b1);
    sweep();

    // Back-to-back, then reset with a pending response
    cycle(1'b1, 1'b0, 4'd0, 8'h00, 1'b1);
    cycle(1'b1, 1'b0, 4'd1, 8'h00, 1'b1);
    cycle(1'b1, 1'b0, 4'd2, 8'h00, 1'b1);
    cycle(1'b1, 1'b0, 4'd7, 8'h00, 1'b0);
    do_reset(1);
    sweep();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
